jpeg_zigzag_sequencer: RTL and testbench

//  Reorders one 8x8 block of quantised DCT coefficients from raster order into JPEG zig-zag order.

---
 rtl/jpeg_zz_pkg.sv | 33 +++
 rtl/jpeg_zz_bank.sv | 66 ++++++
 rtl/jpeg_zigzag_sequencer.sv | 145 ++++++++++++++
 tb/tb_jpeg_zigzag_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_zz_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_zz_pkg
// Shared types and constants for the JPEG zig-zag sequencer.
//   BLK_SIZE     : coefficients per 8x8 block
//   coef_idx_t   : 6-bit index into a block (raster or zig-zag)
//   bank_state_t : life cycle of one coefficient bank
//   ZZ_LUT       : zig-zag position -> raster address
// -----------------------------------------------------------------------------
package jpeg_zz_pkg;

  localparam int BLK_SIZE = 64;

  typedef logic [5:0] coef_idx_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam coef_idx_t ZZ_LUT [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/jpeg_zz_bank.sv
// -----------------------------------------------------------------------------
// jpeg_zz_bank
// One 64-entry coefficient bank: flop storage written in raster order, an
// asynchronous read port addressed by the drain side, the bank state and the
// write pointer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (control only)
//   i_we, i_wdata   : raster write at the internal write pointer
//   i_drain_start   : drain side has taken this bank (FULL -> DRAINING)
//   i_drain_done    : out_last of this bank has been transferred (-> EMPTY)
//   i_raddr/o_rdata : combinational read port
//   o_state         : current bank state
//   o_wr_last       : write pointer sits on the last entry of the block
// -----------------------------------------------------------------------------
module jpeg_zz_bank
  import jpeg_zz_pkg::*;
#(
  parameter int COEF_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic signed [COEF_W-1:0] i_wdata,
  input  logic                     i_drain_start,
  input  logic                     i_drain_done,
  input  coef_idx_t                i_raddr,
  output logic signed [COEF_W-1:0] o_rdata,
  output bank_state_t              o_state,
  output logic                     o_wr_last
);

  logic signed [COEF_W-1:0] r_mem [BLK_SIZE];
  bank_state_t              r_state;
  coef_idx_t                r_wp;
  logic                     w_wr_last;

  assign w_wr_last = (r_wp == 6'd63);

  always_ff @(posedge clk) begin
    if (i_we) r_mem[r_wp] <= i_wdata;
  end

  // The drain side may claim the bank on the very edge of its 64th write
  // (raster 0 is already stored), so the bank can skip straight to DRAINING.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_wp    <= '0;
    end else begin
      if (i_we) begin
        r_wp <= r_wp + 6'd1;
        if (w_wr_last)             r_state <= i_drain_start ? DRAINING : FULL;
        else if (r_state == EMPTY) r_state <= FILLING;
      end else if (i_drain_done) begin
        r_state <= EMPTY;
      end else if (i_drain_start && (r_state == FULL)) begin
        r_state <= DRAINING;
      end
    end
  end

  assign o_rdata   = r_mem[i_raddr];
  assign o_state   = r_state;
  assign o_wr_last = w_wr_last;

endmodule

// File: rtl/jpeg_zigzag_sequencer.sv
// -----------------------------------------------------------------------------
// jpeg_zigzag_sequencer
// Reorders 8x8 blocks of quantised coefficients from raster order into JPEG
// zig-zag order. Coefficients are passed through untouched.
// Build option: define JPEG_ZZ_DBUF_EN for two ping-pong banks (one fills
// while the other drains); otherwise a single bank is used.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : raster input handshake, in_data the coefficient
//   out_valid/out_ready    : zig-zag output handshake (registered outputs)
//   out_data               : coefficient at zig-zag position out_idx
//   out_idx                : zig-zag position 0..63
//   out_last               : high with out_idx == 63
// -----------------------------------------------------------------------------
module jpeg_zigzag_sequencer
  import jpeg_zz_pkg::*;
#(
  parameter int COEF_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_data,
  output logic [5:0]               out_idx,
  output logic                     out_last
);

`ifdef JPEG_ZZ_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  // Bank-select registers only toggle when a second bank exists.
  localparam logic TGL = (NB == 2);

  bank_state_t              w_state   [2];
  logic signed [COEF_W-1:0] w_rdata   [2];
  logic                     w_wr_last [2];

  logic      r_wb;   // bank receiving raster input
  logic      r_nb;   // next bank to drain
  logic      r_rb;   // bank being read by the active drain
  logic      r_ob;   // bank the output register content came from
  logic      r_act;  // drain in progress (more entries to load)
  coef_idx_t r_k;    // next zig-zag position to load

  logic                     r_out_valid;
  logic signed [COEF_W-1:0] r_out_data;
  coef_idx_t                r_out_idx;
  logic                     r_out_last;

  logic                     w_in_ready;
  logic                     w_in_xfer;
  logic                     w_out_free;
  logic                     w_last_xfer;
  logic                     w_nb_ready;
  logic                     w_start;
  logic                     w_load;
  logic                     w_rd_bank;
  logic signed [COEF_W-1:0] w_rdata_sel;

  // Input side: banks fill strictly in turn, so only the write bank matters.
  assign w_in_ready = !rst && ((w_state[r_wb] == EMPTY) || (w_state[r_wb] == FILLING));
  assign w_in_xfer  = in_valid && w_in_ready;

  // Output side
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_last_xfer = r_out_valid && out_ready && r_out_last;

  // A bank may start draining on the edge that writes its 64th coefficient;
  // this removes the turnaround bubble between back-to-back blocks.
  assign w_nb_ready = (w_state[r_nb] == FULL) ||
                      ((w_state[r_nb] == FILLING) && w_in_xfer &&
                       (r_wb == r_nb) && w_wr_last[r_nb]);
  assign w_start    = w_out_free && !r_act && w_nb_ready;
  assign w_load     = w_out_free && (r_act || w_start);

  assign w_rd_bank   = r_act ? r_rb : r_nb;
  assign w_rdata_sel = w_rdata[w_rd_bank];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    jpeg_zz_bank #(.COEF_W(COEF_W)) u_bank (
      .clk           (clk),
      .rst           (rst),
      .i_we          (w_in_xfer && (r_wb == 1'(b))),
      .i_wdata       (in_data),
      .i_drain_start (w_start && (r_nb == 1'(b))),
      .i_drain_done  (w_last_xfer && (r_ob == 1'(b))),
      .i_raddr       (ZZ_LUT[r_k]),
      .o_rdata       (w_rdata[b]),
      .o_state       (w_state[b]),
      .o_wr_last     (w_wr_last[b])
    );
  end

`ifndef JPEG_ZZ_DBUF_EN
  assign w_state[1]   = EMPTY;
  assign w_rdata[1]   = '0;
  assign w_wr_last[1] = 1'b0;
`endif

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb        <= 1'b0;
      r_nb        <= 1'b0;
      r_rb        <= 1'b0;
      r_ob        <= 1'b0;
      r_act       <= 1'b0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_in_xfer && w_wr_last[r_wb]) r_wb <= r_wb ^ TGL;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rdata_sel;
        r_out_idx   <= r_k;
        r_out_last  <= (r_k == 6'd63);
        r_ob        <= w_rd_bank;
        r_k         <= r_k + 6'd1;
        r_act       <= (r_k != 6'd63);
        if (w_start) begin
          r_rb <= r_nb;
          r_nb <= r_nb ^ TGL;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_jpeg_zigzag_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jpeg_zigzag_sequencer
// Directed bench for jpeg_zigzag_sequencer. Expected zig-zag order is derived
// by walking the 8x8 anti-diagonals; block values are base + raster index.
// Define JPEG_ZZ_DBUF_EN to exercise the ping-pong build.
// -----------------------------------------------------------------------------
module tb_jpeg_zigzag_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;

  always #5 clk = ~clk;

  jpeg_zigzag_sequencer #(.COEF_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_n  = 0;

  int q_data [$];
  int q_idx  [$];
  int q_last [$];
  int last_cyc;

  logic pv_stall;
  int   pv_data;
  int   pv_idx;
  logic s_in_rdy;
  logic s_in_x;
  logic s_out_vld;
  int   s_out_idx;

  int g_in_low;
  int g_gaps;
  int g_lowrun;
  int g_rise;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int zz_pos(input int n);
    int r = 0;
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (((r + c) % 2) == 0) begin
        if (c == 7)      r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7)      c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
    return r * 8 + c;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 time unit later.
  task automatic step(input logic r, input logic iv, input logic [11:0] d, input logic ordy);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (!r && pv_stall) begin
      check("hold_vld",  int'(out_valid), 1);
      check("hold_data", int'({20'd0, out_data}), pv_data);
      check("hold_idx",  int'({26'd0, out_idx}), pv_idx);
    end
    s_in_rdy  = in_ready;
    s_in_x    = iv && in_ready;
    s_out_vld = out_valid;
    s_out_idx = int'({26'd0, out_idx});
    if (!r && out_valid && ordy) begin
      q_data.push_back(int'({20'd0, out_data}));
      q_idx.push_back(int'({26'd0, out_idx}));
      q_last.push_back(int'(out_last));
      if (out_last && last_cyc < 0) last_cyc = cyc_n;
    end
    pv_stall = !r && out_valid && !ordy;
    pv_data  = int'({20'd0, out_data});
    pv_idx   = int'({26'd0, out_idx});
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic run_blocks(input int nblk, input int base, input bit rnd, input string nm);
    int          total;
    int          fed;
    int          cycles;
    bit          seen_out;
    logic [11:0] d;
    logic        ordy;
    int          exp_v;
    total    = nblk * 64;
    fed      = 0;
    cycles   = 0;
    seen_out = 0;
    g_in_low = 0;
    g_gaps   = 0;
    g_lowrun = 0;
    g_rise   = -1;
    last_cyc = -1;
    q_data.delete();
    q_idx.delete();
    q_last.delete();
    while (q_data.size() < total && cycles < 3000) begin
      d    = 12'(base + fed);
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1'b0, fed < total, d, ordy);
      if (fed >= 64 && fed < total && !s_in_rdy) g_in_low++;
      if (fed >= 64 && g_rise < 0) begin
        if (!s_in_rdy) g_lowrun++;
        else           g_rise = cyc_n - 1;
      end
      if (seen_out && !s_out_vld && q_data.size() < total) g_gaps++;
      if (s_out_vld) seen_out = 1;
      if (s_in_x) fed++;
      cycles++;
    end
    check({nm, "_count"}, q_data.size(), total);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 12'd0, 1'b1);
    check({nm, "_no_extra"}, q_data.size(), total);
    for (int j = 0; j < total && j < q_data.size(); j++) begin
      exp_v = (base + (j / 64) * 64 + zz_pos(j % 64)) & 32'hFFF;
      check({nm, "_data"}, q_data[j], exp_v);
      check({nm, "_idx"},  q_idx[j],  j % 64);
      check({nm, "_last"}, q_last[j], ((j % 64) == 63) ? 1 : 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  fed;
    bit  found;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 12'd0;
    out_ready = 1'b0;
    pv_stall  = 1'b0;
    last_cyc  = -1;
    @(negedge clk);

    // Reset values
    step(1'b1, 1'b0, 12'd0, 1'b0);
    step(1'b1, 1'b0, 12'd0, 1'b0);
    check("rst_in_ready",  int'(s_in_rdy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'({20'd0, out_data}), 0);
    check("rst_out_idx",   int'({26'd0, out_idx}), 0);
    check("rst_out_last",  int'(out_last), 0);
    step(1'b0, 1'b0, 12'd0, 1'b1);
    check("post_rst_in_ready", int'(s_in_rdy), 1);

    // Order with out_ready high
    run_blocks(1, 0, 1'b0, "order");

    // Random backpressure, negative coefficients
    run_blocks(1, 2048, 1'b1, "bp");

`ifdef JPEG_ZZ_DBUF_EN
    // Three back-to-back blocks through the ping-pong banks
    run_blocks(3, 100, 1'b0, "b2b");
    check("b2b_in_ready_low", g_in_low, 0);
    check("b2b_out_gaps", g_gaps, 0);
`else
    // Single bank: input stalls for the whole drain
    run_blocks(2, 300, 1'b0, "single");
    check("single_in_low_run", g_lowrun, 64);
    check("single_in_ready_rise", g_rise, last_cyc + 1);
`endif

    // Reset mid-fill
    q_data.delete();
    q_idx.delete();
    q_last.delete();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 12'(3000 + i), 1'b1);
    step(1'b1, 1'b0, 12'd0, 1'b1);
    check("mf_no_out", q_data.size(), 0);
    run_blocks(1, 700, 1'b0, "mf");

    // Reset mid-drain at out_idx 30
    fed   = 0;
    found = 0;
    q_data.delete();
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, fed < 64, 12'(1500 + fed), 1'b1);
      if (s_in_x) fed++;
      if (s_out_vld && s_out_idx == 30) found = 1;
    end
    check("md_reach_idx30", int'(found), 1);
    step(1'b1, 1'b0, 12'd0, 1'b1);
    step(1'b0, 1'b0, 12'd0, 1'b1);
    check("md_out_valid", int'(s_out_vld), 0);
    check("md_out_idx",   s_out_idx, 0);
    check("md_in_ready",  int'(s_in_rdy), 1);
    q_data.delete();
    for (int i = 0; i < 80; i++) step(1'b0, 1'b0, 12'd0, 1'b1);
    check("md_no_stale", q_data.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
